// File: rtl/jk_pattern_driver.sv
// Command-side driver for a single-bit ON/OFF J/K target: emits j/k pulses so the
// target traces ON for on_len cycles, OFF for off_len cycles, reps times or until stop.
module jk_pattern_driver #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic [CW-1:0] on_len,
  input  logic [CW-1:0] off_len,
  input  logic [CW-1:0] reps,
  output logic          j,
  output logic          k,
  output logic          tgt_on,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ARM  = 3'd1;
  localparam logic [2:0] ON   = 3'd2;
  localparam logic [2:0] OFF  = 3'd3;
  localparam logic [2:0] KILL = 3'd4;

  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] on_lat;
  logic [CW-1:0] off_lat;
  logic [CW-1:0] reps_lat;
  logic [CW-1:0] rep_cnt;
  logic          last_rep;
  logic          on_next;

  // Same update rule the target FSM applies to its own out.
  function automatic logic mirror_next(input logic jv, input logic kv, input logic cur);
    return jv ? 1'b1 : (kv ? 1'b0 : cur);
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + ONE;
  endfunction

  // j/k come from registered state only, so start/stop never reach the target combinationally.
  always_comb begin
    j        = (state == ARM) || ((state == OFF) && (cnt == '0));
    k        = ((state == ON) && (cnt == '0)) || (state == KILL);
    busy     = (state != IDLE);
    on_next  = mirror_next(j, k, tgt_on);
    last_rep = (reps_lat != '0) &&
               (({1'b0, rep_cnt} + {{CW{1'b0}}, 1'b1}) == {1'b0, reps_lat});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      on_lat   <= '0;
      off_lat  <= '0;
      reps_lat <= '0;
      rep_cnt  <= '0;
      tgt_on   <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done   <= 1'b0;
      err    <= 1'b0;
      tgt_on <= on_next;
      case (state)
        IDLE: begin
          if (start) begin
            if (on_len != '0) begin
              on_lat   <= on_len;
              off_lat  <= (off_len == '0) ? ONE : off_len;
              reps_lat <= reps;
              rep_cnt  <= '0;
              state    <= ARM;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ARM: begin
          if (stop) begin
            state <= KILL;
          end else begin
            cnt   <= on_lat - ONE;
            state <= ON;
          end
        end
        ON: begin
          if (stop) begin
            state <= on_next ? KILL : IDLE;
            done  <= !on_next;
          end else if (cnt == '0) begin
            rep_cnt <= sat_inc(rep_cnt);
            if (last_rep) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              cnt   <= off_lat - ONE;
              state <= OFF;
            end
          end else begin
            cnt <= cnt - ONE;
          end
        end
        OFF: begin
          if (stop) begin
            state <= on_next ? KILL : IDLE;
            done  <= !on_next;
          end else if (cnt == '0) begin
            cnt   <= on_lat - ONE;
            state <= ON;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        KILL: begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_pattern_driver.sv
// Directed bench for jk_pattern_driver with a reference J/K target model.
module tb_jk_pattern_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] on_len = 8'd0;
  logic [7:0] off_len = 8'd0;
  logic [7:0] reps = 8'd0;
  logic       j, k, tgt_on, busy, done, err;
  logic       ref_on;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected {j,k,tgt_on,busy,done,err} for C1, C2, ...
  logic [5:0] exp_q[$];

  jk_pattern_driver #(.CW(8)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .on_len(on_len), .off_len(off_len), .reps(reps),
    .j(j), .k(k), .tgt_on(tgt_on), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Independent target: goes ON on j, OFF on k.
  always @(posedge clk) begin
    if (reset) ref_on <= 1'b0;
    else if (j) ref_on <= 1'b1;
    else if (k) ref_on <= 1'b0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [5:0] act, input logic [5:0] expv);
    n_cmp++;
    assert (act === expv) else begin
      n_bad++;
      $error("FAIL %s: got jk/on/busy/done/err=%b want %b", tag, act, expv);
    end
    n_cmp++;
    assert (tgt_on === ref_on && !(j && k)) else begin
      n_bad++;
      $error("FAIL %s mirror: tgt_on=%b j=%b k=%b want ref_on=%b no j&k", tag, tgt_on, j, k, ref_on);
    end
  endtask

  // Walks exp_q from C1; injects stop, reset or a start-while-busy poke at given cycles.
  task automatic run(input string tag, input int stop_at, input int reset_at, input int poke_at);
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("%s C%0d", tag, i + 1), {j, k, tgt_on, busy, done, err}, exp_q[i]);
      stop  = (i + 1 == stop_at);
      reset = (i + 1 == reset_at);
      if (i + 1 == poke_at) begin
        start  = 1'b1;
        on_len = 8'd0;
      end else begin
        start = 1'b0;
      end
      step();
    end
    stop  = 1'b0;
    reset = 1'b0;
    start = 1'b0;
  endtask

  task automatic launch(input logic [7:0] on_v, input logic [7:0] off_v, input logic [7:0] reps_v);
    on_len  = on_v;
    off_len = off_v;
    reps    = reps_v;
    start   = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    step();
    step();
    reset = 1'b0;
    step();
    chk("reset", {j, k, tgt_on, busy, done, err}, 6'b000000);

    // Scenario 1: on=3 off=2 reps=2
    launch(8'd3, 8'd2, 8'd2);
    exp_q = '{6'b100100, 6'b001100, 6'b001100, 6'b011100, 6'b000100,
              6'b100100, 6'b001100, 6'b001100, 6'b011100, 6'b000010};
    run("s1", 0, 0, 0);

    // Scenario 2: on=1 off=0 reps=3
    launch(8'd1, 8'd0, 8'd3);
    exp_q = '{6'b100100, 6'b011100, 6'b100100, 6'b011100, 6'b100100,
              6'b011100, 6'b000010};
    run("s2", 0, 0, 0);

    // Scenario 3: illegal start then a legal one
    launch(8'd0, 8'd4, 8'd1);
    exp_q = '{6'b000001, 6'b000000};
    run("s3err", 0, 0, 0);
    launch(8'd1, 8'd0, 8'd1);
    exp_q = '{6'b100100, 6'b011100, 6'b000010};
    run("s3ok", 0, 0, 0);

    // Scenario 4: continuous, stop while ON
    launch(8'd2, 8'd1, 8'd0);
    exp_q = '{6'b100100, 6'b001100, 6'b011100, 6'b100100, 6'b001100,
              6'b011100, 6'b000010, 6'b000000};
    run("s4", 5, 0, 0);

    // Scenario 5: continuous, stop in the OFF j cycle
    launch(8'd2, 8'd1, 8'd0);
    exp_q = '{6'b100100, 6'b001100, 6'b011100, 6'b100100, 6'b011100,
              6'b000010, 6'b000000};
    run("s5", 4, 0, 0);

    // Scenario 6a: reset mid-pattern, no done afterwards
    launch(8'd3, 8'd2, 8'd2);
    exp_q = '{6'b100100, 6'b001100, 6'b001100, 6'b000000, 6'b000000};
    run("s6rst", 0, 3, 0);

    // Scenario 6b: start (with on_len=0) while busy is ignored
    launch(8'd3, 8'd2, 8'd2);
    exp_q = '{6'b100100, 6'b001100, 6'b001100, 6'b011100, 6'b000100,
              6'b100100, 6'b001100, 6'b001100, 6'b011100, 6'b000010, 6'b000000};
    run("s6busy", 0, 0, 2);

    // Scenario 6c: start and stop together in IDLE, start wins
    on_len  = 8'd1;
    off_len = 8'd0;
    reps    = 8'd1;
    start   = 1'b1;
    stop    = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    exp_q = '{6'b100100, 6'b011100, 6'b000010};
    run("s6both", 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
